capture_readout: RTL and testbench

- Downstream stage of the logic-capture engine: once a capture has filled BRAM, this block reads the stored 8-bit samples back out, address 0 upward.
- Presents the samples as a valid/ready byte stream to the host-link transmitter (UART TX).
- Software starts and aborts it via control-register bits and sees progress in status bits.

---
 rtl/capture_readout.sv | 198 +++++++++++++++++++
 tb/tb_capture_readout.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - BRAM capture readout to valid/ready byte stream; optional header via READOUT_HEADER_EN
module capture_readout #(
    parameter int ADDR_W     = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] sample_count,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   bytes_sent
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
`ifdef READOUT_HEADER_EN
        , S_HEADER = 3'd5
`endif
    } state_t;

    localparam logic [1:0]        LAT   = RD_LATENCY[1:0];
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   B_ONE = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]          wait_q, wait_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     bytes_sent_q, bytes_sent_d;
    logic                handshake;

`ifdef READOUT_HEADER_EN
    logic [1:0]          hdr_idx_q, hdr_idx_d;
    logic [31:0]         cnt_ext;

    assign cnt_ext = 32'(remaining_q);

    // Header byte for a given index: sync marker then 24-bit big-endian count
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [31:0] cnt);
        case (idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = cnt[23:16];
            2'd2:    hdr_byte = cnt[15:8];
            default: hdr_byte = cnt[7:0];
        endcase
    endfunction
`endif

    assign handshake  = out_valid_q && out_ready;
    assign bram_en    = (state_q == S_ISSUE);
    assign bram_addr  = rd_addr_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bytes_sent = bytes_sent_q;

    // State and datapath registers; async reset clears every output immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            rd_addr_q    <= '0;
            wait_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bytes_sent_q <= '0;
`ifdef READOUT_HEADER_EN
            hdr_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            rd_addr_q    <= rd_addr_d;
            wait_q       <= wait_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bytes_sent_q <= bytes_sent_d;
`ifdef READOUT_HEADER_EN
            hdr_idx_q    <= hdr_idx_d;
`endif
        end
    end

    // Next-state logic: one BRAM read per byte, no prefetch; abort overrides everything
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        rd_addr_d    = rd_addr_q;
        wait_d       = wait_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        bytes_sent_d = bytes_sent_q;
`ifdef READOUT_HEADER_EN
        hdr_idx_d    = hdr_idx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (sample_count != '0) begin
                        remaining_d  = sample_count;
                        rd_addr_d    = '0;
                        bytes_sent_d = '0;
                        busy_d       = 1'b1;
`ifdef READOUT_HEADER_EN
                        hdr_idx_d    = 2'd0;
                        out_data_d   = 8'hA5;
                        out_valid_d  = 1'b1;
                        state_d      = S_HEADER;
`else
                        state_d      = S_ISSUE;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
`ifdef READOUT_HEADER_EN
            S_HEADER: begin
                if (handshake) begin
                    if (hdr_idx_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        state_d     = S_ISSUE;
                    end else begin
                        hdr_idx_d  = hdr_idx_q + 2'd1;
                        out_data_d = hdr_byte(hdr_idx_q + 2'd1, cnt_ext);
                    end
                end
            end
`endif
            S_ISSUE: begin
                wait_d  = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q <= 2'd1) begin
                    out_data_d  = bram_rdata;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_PRESENT: begin
                if (handshake) begin
                    out_valid_d  = 1'b0;
                    bytes_sent_d = bytes_sent_q + B_ONE;
                    remaining_d  = remaining_q - A_ONE;
                    rd_addr_d    = rd_addr_q + A_ONE;
                    if (remaining_q == A_ONE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - scoreboard bench for capture_readout (READOUT_HEADER_EN aware)
module tb_capture_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance: ADDR_W=18, RD_LATENCY=1 ----------------
    logic        a_start, a_abort, a_bram_en, a_out_valid, a_out_ready, a_busy, a_done;
    logic [17:0] a_sample_count, a_bram_addr;
    logic [7:0]  a_bram_rdata, a_out_data;
    logic [18:0] a_bytes_sent;

    capture_readout #(.ADDR_W(18), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .sample_count(a_sample_count), .bram_en(a_bram_en), .bram_addr(a_bram_addr),
        .bram_rdata(a_bram_rdata), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy), .done(a_done), .bytes_sent(a_bytes_sent)
    );

    always @(posedge clk) if (a_bram_en) a_bram_rdata <= a_bram_addr[7:0] ^ 8'h3C;

    // ---------------- small instance: ADDR_W=4, RD_LATENCY=3 ----------------
    logic        s_start, s_abort, s_bram_en, s_out_valid, s_out_ready, s_busy, s_done;
    logic [3:0]  s_sample_count, s_bram_addr;
    logic [7:0]  s_bram_rdata, s_r1, s_r2;
    logic [7:0]  s_out_data;
    logic [4:0]  s_bytes_sent;

    capture_readout #(.ADDR_W(4), .RD_LATENCY(3)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
        .sample_count(s_sample_count), .bram_en(s_bram_en), .bram_addr(s_bram_addr),
        .bram_rdata(s_bram_rdata), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .busy(s_busy), .done(s_done), .bytes_sent(s_bytes_sent)
    );

    always @(posedge clk) begin
        if (s_bram_en) s_r1 <= {4'h0, s_bram_addr} ^ 8'h3C;
        s_r2         <= s_r1;
        s_bram_rdata <= s_r2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hdr_byte(input int i, input int cnt);
        logic [31:0] c;
        c = cnt;
        case (i)
            0:       hdr_byte = 8'hA5;
            1:       hdr_byte = c[23:16];
            2:       hdr_byte = c[15:8];
            default: hdr_byte = c[7:0];
        endcase
    endfunction

    function automatic logic [7:0] bdat(input int k);
        logic [31:0] kk;
        kk = k;
        bdat = kk[7:0] ^ 8'h3C;
    endfunction

    // ---------------- main monitor / scoreboard ----------------
    logic [7:0] a_q[$];
    int   a_hs = 0, a_en = 0, a_done_cnt = 0, a_exp_addr = 0, a_issue_cyc = 0, a_valid_seen = 0;
    logic a_busy_seen = 1'b0, a_issued = 1'b0, a_prev_v = 1'b0, a_prev_r = 1'b0;
    logic [7:0] a_prev_d = 8'h00;

    always begin
        @(negedge clk);
        if (reset) begin
            a_prev_v = 1'b0;
            a_issued = 1'b0;
        end else begin
            if (a_bram_en) begin
                check_eq("a_addr", a_bram_addr, a_exp_addr);
                a_exp_addr++;
                a_en++;
                a_issue_cyc = cyc;
                a_issued = 1'b1;
            end
            if (a_out_valid && !a_prev_v && a_issued) begin
                check_eq("a_latency", cyc - a_issue_cyc, 2);
                a_issued = 1'b0;
            end
            if (a_prev_v && !a_prev_r) begin
                check_eq("a_hold_valid", a_out_valid, 1);
                check_eq("a_hold_data", a_out_data, a_prev_d);
            end
            if (a_out_valid) a_valid_seen++;
            if (a_out_valid && a_out_ready) begin
                a_hs++;
                check_eq("a_q_nonempty", a_q.size(), 1 + ((a_q.size() > 1) ? a_q.size() - 1 : 0));
                if (a_q.size() > 0) check_eq("a_data", a_out_data, a_q.pop_front());
            end
            if (a_done) a_done_cnt++;
            if (a_busy) a_busy_seen = 1'b1;
            a_prev_v = a_out_valid;
            a_prev_r = a_out_ready;
            a_prev_d = a_out_data;
        end
    end

    // ---------------- small monitor / scoreboard ----------------
    logic [7:0] s_q[$];
    int   s_hs = 0, s_exp_addr = 0, s_issue_cyc = 0;
    logic s_issued = 1'b0, s_prev_v = 1'b0;

    always begin
        @(negedge clk);
        if (reset) begin
            s_prev_v = 1'b0;
            s_issued = 1'b0;
        end else begin
            if (s_bram_en) begin
                check_eq("s_addr", s_bram_addr, s_exp_addr);
                s_exp_addr++;
                s_issue_cyc = cyc;
                s_issued = 1'b1;
            end
            if (s_out_valid && !s_prev_v && s_issued) begin
                check_eq("s_latency", cyc - s_issue_cyc, 4);
                s_issued = 1'b0;
            end
            if (s_out_valid && s_out_ready) begin
                s_hs++;
                if (s_q.size() == 0) check_eq("s_extra_byte", s_out_data, 32'hFFFF_FFFF);
                else check_eq("s_data", s_out_data, s_q.pop_front());
            end
            s_prev_v = s_out_valid;
        end
    end

    // ---------------- backpressure driver for main instance ----------------
    logic bp_mode = 1'b0;
    int   stall = 0;

    always begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
            if (!a_out_valid) begin
                a_out_ready = 1'b0;
            end else if (stall < 5) begin
                a_out_ready = 1'b0;
                stall++;
            end else begin
                a_out_ready = 1'b1;
                stall = 0;
            end
        end
    end

    task automatic a_go(input int cnt, input int npush);
        @(posedge clk);
        #1;
`ifdef READOUT_HEADER_EN
        if (cnt != 0) for (int i = 0; i < 4; i++) a_q.push_back(hdr_byte(i, cnt));
`endif
        for (int k = 0; k < npush; k++) a_q.push_back(bdat(k));
        a_exp_addr = 0;
        a_sample_count = cnt[17:0];
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
    endtask

    task automatic s_go(input int cnt);
        @(posedge clk);
        #1;
`ifdef READOUT_HEADER_EN
        for (int i = 0; i < 4; i++) s_q.push_back(hdr_byte(i, cnt));
`endif
        for (int k = 0; k < cnt; k++) s_q.push_back(bdat(k));
        s_exp_addr = 0;
        s_sample_count = cnt[3:0];
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
    endtask

    task automatic a_wait_done(input string tag, input int budget);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(negedge clk);
            #1;
            if (a_done) got = 1'b1;
            n++;
        end
        check_eq(tag, got, 1);
    endtask

    task automatic s_wait_done(input string tag, input int budget);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(negedge clk);
            #1;
            if (s_done) got = 1'b1;
            n++;
        end
        check_eq(tag, got, 1);
    endtask

    task automatic a_wait_hs(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (n < budget && a_hs < target) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq(tag, a_hs, target);
    endtask

    task automatic a_clear_stats();
        a_hs = 0;
        a_en = 0;
        a_done_cnt = 0;
        a_valid_seen = 0;
        a_busy_seen = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_sample_count = '0; a_out_ready = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_sample_count = '0; s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_bram_en", a_bram_en, 0);
        check_eq("rst_bram_addr", a_bram_addr, 0);
        check_eq("rst_out_data", a_out_data, 0);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_bytes_sent", a_bytes_sent, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic readout, ready tied high
        a_clear_stats();
        a_go(4, 4);
        a_wait_done("basic_done", 200);
        check_eq("basic_busy_at_done", a_busy, 0);
        check_eq("basic_bytes_sent", a_bytes_sent, 4);
        @(negedge clk);
        #1;
        check_eq("basic_done_width", a_done, 0);
        check_eq("basic_done_count", a_done_cnt, 1);
        check_eq("basic_reads", a_en, 4);
        check_eq("basic_queue_left", a_q.size(), 0);

        // backpressure: 5 stall cycles on every byte
        a_clear_stats();
        bp_mode = 1'b1;
        a_out_ready = 1'b0;
        a_go(3, 3);
        a_wait_done("bp_done", 400);
        bp_mode = 1'b0;
        check_eq("bp_handshakes", a_hs, 3 + ((a_q.size() == 0) ? 0 : 1000));
        check_eq("bp_reads", a_en, 3);
        check_eq("bp_bytes_sent", a_bytes_sent, 3);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;

        // zero count: done only
        a_clear_stats();
        a_go(0, 0);
        repeat (4) @(negedge clk);
        check_eq("zero_done_count", a_done_cnt, 1);
        check_eq("zero_busy_seen", a_busy_seen, 0);
        check_eq("zero_valid_seen", a_valid_seen, 0);

        // abort after the 4th handshake of a 10-byte readout
        a_clear_stats();
        a_go(10, 10);
        a_wait_hs("abort_reach4", 4, 200);
        @(posedge clk);
        #1;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        check_eq("abort_busy", a_busy, 0);
        check_eq("abort_valid", a_out_valid, 0);
        check_eq("abort_bram_en", a_bram_en, 0);
        check_eq("abort_bytes_sent", a_bytes_sent, 4);
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", a_done_cnt, 0);
        check_eq("abort_hs_total", a_hs, 4);
        a_q.delete();

        // abort and start together in IDLE: start ignored
        @(posedge clk);
        #1;
        a_sample_count = 18'd5;
        a_start = 1'b1;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_abort = 1'b0;
        check_eq("abort_start_busy", a_busy, 0);
        check_eq("abort_start_bram_en", a_bram_en, 0);

        // fresh readout restarts at address 0
        a_clear_stats();
        a_go(3, 3);
        a_wait_done("restart_done", 200);
        check_eq("restart_bytes_sent", a_bytes_sent, 3);
        check_eq("restart_queue_left", a_q.size(), 0);

`ifdef READOUT_HEADER_EN
        // header with a large count, aborted after header plus three data bytes
        a_clear_stats();
        a_go(32'h1_0203, 3);
        a_wait_hs("hdr_reach", 7, 200);
        @(posedge clk);
        #1;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        check_eq("hdr_bytes_sent", a_bytes_sent, 3);
        check_eq("hdr_queue_left", a_q.size(), 0);
        a_q.delete();
`endif

        // latency 3 and maximum count on the small instance
        s_go(2);
        s_wait_done("s_lat_done", 100);
        check_eq("s_lat_bytes_sent", s_bytes_sent, 2);
        s_go(15);
        s_wait_done("s_max_done", 400);
        check_eq("s_max_bytes_sent", s_bytes_sent, 15);
        check_eq("s_max_hs", s_hs, 17);
        check_eq("s_max_last_addr", s_exp_addr, 15);
        check_eq("s_queue_left", s_q.size(), 0);

        // asynchronous reset while a byte is presented
        a_out_ready = 1'b0;
        a_go(6, 6);
        begin
            int n;
            n = 0;
            while (n < 50 && !a_out_valid) begin
                @(negedge clk);
                n++;
            end
            check_eq("rst_mid_valid_before", a_out_valid, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_valid", a_out_valid, 0);
        check_eq("rst_mid_busy", a_busy, 0);
        check_eq("rst_mid_bram_en", a_bram_en, 0);
        check_eq("rst_mid_out_data", a_out_data, 0);
        check_eq("rst_mid_bytes_sent", a_bytes_sent, 0);
        check_eq("rst_mid_done", a_done, 0);
        a_q.delete();
        @(negedge clk);
        reset = 1'b0;
        a_out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
